// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WIDTH-bit add/subtract computed one nibble per clock through a
// single 4-bit ripple-carry slice, with valid/ready handshakes on both sides.
module rca44 (
  input  logic       cin,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign s[g]   = a[g] ^ b[g] ^ c[g];
    assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
  assign cout = c[4];
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, cout_q, ovf_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [3:0]       s_d;
  logic             c_d, last_d;
  // b_q holds the already-inverted operand for subtraction
  rca44 u_slice (
    .cin  (carry_q),
    .a    (a_q[{idx_q, 2'b00} +: 4]),
    .b    (b_q[{idx_q, 2'b00} +: 4]),
    .s    (s_d),
    .cout (c_d)
  );
  assign last_d    = idx_q == IW'(NIB - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= cin ^ sub;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= s_d;
          carry_q <= c_d;
          idx_q   <= last_d ? '0 : idx_q + IW'(1);
          if (last_d) begin
            cout_q      <= c_d;
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_d[3] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
